audio_sample_scheduler: RTL and testbench



---
 rtl/audio_sample_scheduler.sv | 115 +++++++++++
 tb/tb_audio_sample_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_scheduler.sv
// Buffers stereo L-PCM sample pairs and loads up to four of them per granted
// HDMI audio sample packet, tracking the 192-frame IEC 60958 channel-status index.
module audio_sample_scheduler #(
    parameter int FIFO_DEPTH   = 8,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]              sample_left,
    input  logic [SAMPLE_WIDTH-1:0]              sample_right,
    input  logic                                 packet_grant,
    input  logic                                 packet_done,
    output logic                                 packet_ready,
    output logic [7:0]                           frame_counter,
    output logic [3:0][1:0][SAMPLE_WIDTH-1:0]    audio_sample_word,
    output logic [3:0]                           audio_sample_word_present,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
    output logic                                 overflow,
    input  logic                                 overflow_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;
    typedef logic [1:0][SAMPLE_WIDTH-1:0] pair_t;

    state_t          state;
    pair_t           mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [7:0]      fc;

    logic            grant_take;
    logic [2:0]      n;
    logic            push;
    logic            drop;
    logic [LW-1:0]   level_next;
    logic [8:0]      fc_sum;
    logic [7:0]      fc_next;
    pair_t [3:0]     lane_next;
    logic [3:0]      present_next;

    assign grant_take = (state == REQ) && packet_grant;
    assign n          = !grant_take ? 3'd0 :
                        (fifo_level > LW'(4)) ? 3'd4 : 3'(fifo_level);
    // A pop in the same edge frees room, so a full FIFO still accepts the pair.
    assign push       = sample_valid && ((fifo_level < LW'(FIFO_DEPTH)) || (n != 3'd0));
    assign drop       = sample_valid && !push;
    assign level_next = fifo_level - LW'(n) + LW'(push);
    assign fc_sum     = {1'b0, fc} + 9'(n);
    assign fc_next    = (fc_sum >= 9'd192) ? 8'(fc_sum - 9'd192) : fc_sum[7:0];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign present_next[i] = 3'(i) < n;
            assign lane_next[i]    = present_next[i] ? mem[rd_ptr + AW'(i)] : '0;
        end
    endgenerate

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {sample_right, sample_left};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                     <= IDLE;
            packet_ready              <= 1'b0;
            rd_ptr                    <= '0;
            wr_ptr                    <= '0;
            fifo_level                <= '0;
            fc                        <= '0;
            frame_counter             <= '0;
            audio_sample_word         <= '0;
            audio_sample_word_present <= '0;
            overflow                  <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr + AW'(n);
            fifo_level <= level_next;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clear)
                overflow <= 1'b0;

            if (grant_take) begin
                audio_sample_word         <= lane_next;
                audio_sample_word_present <= present_next;
                frame_counter             <= fc;
                fc                        <= fc_next;
            end

            case (state)
                IDLE: if (fifo_level != '0) begin
                    state        <= REQ;
                    packet_ready <= 1'b1;
                end
                REQ: if (packet_grant) begin
                    state        <= SEND;
                    packet_ready <= 1'b0;
                end
                SEND: if (packet_done) begin
                    state        <= (level_next != '0) ? REQ : IDLE;
                    packet_ready <= (level_next != '0);
                end
                default: begin
                    state        <= IDLE;
                    packet_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench: pairs are queued when accepted and compared when a grant loads lanes.
module tb_audio_sample_scheduler;
    localparam int DEPTH = 8;
    localparam int SW    = 24;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       sample_valid = 1'b0;
    logic [SW-1:0]              sample_left = '0;
    logic [SW-1:0]              sample_right = '0;
    logic                       packet_grant = 1'b0;
    logic                       packet_done = 1'b0;
    logic                       packet_ready;
    logic [7:0]                 frame_counter;
    logic [3:0][1:0][SW-1:0]    audio_sample_word;
    logic [3:0]                 audio_sample_word_present;
    logic [$clog2(DEPTH):0]     fifo_level;
    logic                       overflow;
    logic                       overflow_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [1:0][SW-1:0]         q[$];
    logic [3:0][1:0][SW-1:0]    exp_word = '0;
    logic [3:0]                 exp_present = '0;
    logic [7:0]                 exp_fcout = '0;
    int                         model_fc = 0;

    audio_sample_scheduler #(.FIFO_DEPTH(DEPTH), .SAMPLE_WIDTH(SW)) dut (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample_left(sample_left), .sample_right(sample_right),
        .packet_grant(packet_grant), .packet_done(packet_done),
        .packet_ready(packet_ready), .frame_counter(frame_counter),
        .audio_sample_word(audio_sample_word),
        .audio_sample_word_present(audio_sample_word_present),
        .fifo_level(fifo_level), .overflow(overflow), .overflow_clear(overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        @(negedge clk);
        sample_valid = 1'b1; sample_left = l; sample_right = r;
        if (q.size() < DEPTH) q.push_back({r, l});
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!packet_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!packet_ready) begin
            errors++;
            $display("FAIL wait_ready: packet_ready=%b after %0d cycles, required 1", packet_ready, k);
        end
    endtask

    task automatic do_grant(input bit with_s, input logic [SW-1:0] l, input logic [SW-1:0] r,
                            input bit with_done);
        int pre, n;
        wait_ready();
        @(negedge clk);
        packet_grant = 1'b1;
        packet_done  = with_done;
        if (with_s) begin
            sample_valid = 1'b1; sample_left = l; sample_right = r;
        end
        pre = q.size();
        n = (pre > 4) ? 4 : pre;
        exp_word = '0;
        for (int i = 0; i < n; i++) exp_word[i] = q.pop_front();
        exp_present = 4'((1 << n) - 1);
        exp_fcout = 8'(model_fc);
        model_fc = (model_fc + n) % 192;
        if (with_s && (pre < DEPTH || n > 0)) q.push_back({r, l});
        @(negedge clk);
        packet_grant = 1'b0; packet_done = 1'b0; sample_valid = 1'b0;
    endtask

    task automatic do_done();
        @(negedge clk);
        packet_done = 1'b1;
        @(negedge clk);
        packet_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({packet_ready, frame_counter, audio_sample_word_present, fifo_level, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b fc=%0d present=%b level=%0d ovf=%b, required all 0",
                     packet_ready, frame_counter, audio_sample_word_present, fifo_level, overflow);
        end
        checks++;
        if (audio_sample_word !== '0) begin
            errors++;
            $display("FAIL reset_lanes: got %h required 0", audio_sample_word);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 3; i++) push_pair(SW'(i), SW'(24'h100000 + i));
        checks++;
        if (fifo_level !== 3) begin
            errors++; $display("FAIL basic_level: got %0d required 3", fifo_level);
        end
        do_grant(0, '0, '0, 0);
        checks++;
        if (audio_sample_word_present !== 4'b0111 || exp_present !== 4'b0111) begin
            errors++; $display("FAIL basic_present: got %b required 0111", audio_sample_word_present);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (audio_sample_word[i] !== exp_word[i]) begin
                errors++; $display("FAIL basic_lane%0d: got %h required %h", i, audio_sample_word[i], exp_word[i]);
            end
        end
        checks++;
        if (frame_counter !== 8'd0 || packet_ready !== 1'b0) begin
            errors++; $display("FAIL basic_fc_ready: fc=%0d ready=%b required fc=0 ready=0", frame_counter, packet_ready);
        end
        do_done();
        repeat (2) @(negedge clk);
        checks++;
        if (audio_sample_word_present !== 4'b0111 || audio_sample_word[2] !== exp_word[2] || packet_ready !== 1'b0) begin
            errors++; $display("FAIL basic_stable: present=%b ready=%b required 0111/0", audio_sample_word_present, packet_ready);
        end
        push_pair(24'h000004, 24'h100004);
        do_grant(0, '0, '0, 0);
        checks++;
        if (frame_counter !== 8'd3) begin
            errors++; $display("FAIL basic_next_fc: got %0d required 3", frame_counter);
        end
        do_done();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 10; i++) push_pair(SW'(24'h200000 + i), SW'(24'h300000 + i));
        checks++;
        if (fifo_level !== 8 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set: level=%0d ovf=%b required 8/1", fifo_level, overflow);
        end
        @(negedge clk); overflow_clear = 1'b1;
        @(negedge clk); overflow_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b required 0", overflow);
        end
        for (int p = 0; p < 2; p++) begin
            do_grant(0, '0, '0, 0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (audio_sample_word[i] !== exp_word[i]) begin
                    errors++; $display("FAIL ovf_lane%0d_pkt%0d: got %h required %h", i, p, audio_sample_word[i], exp_word[i]);
                end
            end
            checks++;
            if (frame_counter !== exp_fcout) begin
                errors++; $display("FAIL ovf_fc_pkt%0d: got %0d required %0d", p, frame_counter, exp_fcout);
            end
            do_done();
        end
        checks++;
        if (fifo_level !== 0 || q.size() != 0) begin
            errors++; $display("FAIL ovf_drained: level=%0d required 0 (pairs 9,10 must be absent)", fifo_level);
        end
    endtask

    task automatic test_wrap();
        int k;
        while (model_fc != 190) begin
            k = (190 - model_fc > 4) ? 4 : 190 - model_fc;
            for (int i = 0; i < k; i++) push_pair(SW'($urandom), SW'($urandom));
            do_grant(0, '0, '0, 0);
            do_done();
        end
        for (int i = 0; i < 4; i++) push_pair(SW'(24'h400000 + i), SW'(24'h500000 + i));
        do_grant(0, '0, '0, 0);
        checks++;
        if (frame_counter !== 8'd190 || audio_sample_word_present !== 4'b1111) begin
            errors++; $display("FAIL wrap_fc: fc=%0d present=%b required 190/1111", frame_counter, audio_sample_word_present);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (audio_sample_word[i] !== exp_word[i]) begin
                errors++; $display("FAIL wrap_lane%0d: got %h required %h", i, audio_sample_word[i], exp_word[i]);
            end
        end
        do_done();
        push_pair(24'h0000aa, 24'h0000bb);
        do_grant(0, '0, '0, 0);
        checks++;
        if (frame_counter !== 8'd2) begin
            errors++; $display("FAIL wrap_next_fc: got %0d required 2", frame_counter);
        end
        do_done();
    endtask

    task automatic test_full_grant();
        for (int i = 0; i < 8; i++) push_pair(SW'(24'h600000 + i), SW'(24'h700000 + i));
        checks++;
        if (fifo_level !== 8) begin
            errors++; $display("FAIL full_level: got %0d required 8", fifo_level);
        end
        do_grant(1, 24'h6000ff, 24'h7000ff, 0);
        checks++;
        if (fifo_level !== 5 || overflow !== 1'b0) begin
            errors++; $display("FAIL full_write_pop: level=%0d ovf=%b required 5/0", fifo_level, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (audio_sample_word[i] !== exp_word[i]) begin
                errors++; $display("FAIL full_lane%0d: got %h required %h", i, audio_sample_word[i], exp_word[i]);
            end
        end
        do_done();
        for (int p = 0; p < 2; p++) begin
            do_grant(0, '0, '0, 0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (audio_sample_word[i] !== exp_word[i]) begin
                    errors++; $display("FAIL full_drain_lane%0d_pkt%0d: got %h required %h", i, p, audio_sample_word[i], exp_word[i]);
                end
            end
            do_done();
        end
    endtask

    task automatic test_ignored();
        @(negedge clk); packet_grant = 1'b1;
        @(negedge clk); packet_grant = 1'b0;
        checks++;
        if (packet_ready !== 1'b0 || audio_sample_word_present !== exp_present || frame_counter !== exp_fcout) begin
            errors++; $display("FAIL idle_grant: ready=%b present=%b fc=%0d required 0/%b/%0d",
                               packet_ready, audio_sample_word_present, frame_counter, exp_present, exp_fcout);
        end
        push_pair(24'h0000c1, 24'h0000d1);
        wait_ready();
        do_done();
        checks++;
        if (packet_ready !== 1'b1 || fifo_level !== 1 || audio_sample_word_present !== exp_present) begin
            errors++; $display("FAIL req_done: ready=%b level=%0d required 1/1", packet_ready, fifo_level);
        end
        do_grant(0, '0, '0, 1);
        checks++;
        if (packet_ready !== 1'b0 || audio_sample_word_present !== 4'b0001 || audio_sample_word[0] !== exp_word[0]) begin
            errors++; $display("FAIL grant_done: ready=%b present=%b lane0=%h required 0/0001/%h",
                               packet_ready, audio_sample_word_present, audio_sample_word[0], exp_word[0]);
        end
        @(negedge clk); packet_grant = 1'b1;
        @(negedge clk); packet_grant = 1'b0;
        checks++;
        if (packet_ready !== 1'b0 || audio_sample_word_present !== 4'b0001 || frame_counter !== exp_fcout) begin
            errors++; $display("FAIL send_grant: ready=%b present=%b fc=%0d required 0/0001/%0d",
                               packet_ready, audio_sample_word_present, frame_counter, exp_fcout);
        end
        do_done();
        repeat (2) @(negedge clk);
        checks++;
        if (packet_ready !== 1'b0) begin
            errors++; $display("FAIL done_to_idle: ready=%b required 0", packet_ready);
        end
    endtask

    task automatic test_reset_mid_send();
        for (int i = 0; i < 6; i++) push_pair(SW'(24'h800000 + i), SW'(24'h900000 + i));
        do_grant(0, '0, '0, 0);
        for (int i = 0; i < 4; i++) push_pair(SW'(24'ha00000 + i), SW'(24'hb00000 + i));
        checks++;
        if (fifo_level !== 6 || packet_ready !== 1'b0) begin
            errors++; $display("FAIL mid_send_level: level=%0d ready=%b required 6/0", fifo_level, packet_ready);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({packet_ready, frame_counter, audio_sample_word_present, fifo_level, overflow} !== '0 ||
            audio_sample_word !== '0) begin
            errors++; $display("FAIL async_reset: ready=%b fc=%0d present=%b level=%0d required all 0",
                               packet_ready, frame_counter, audio_sample_word_present, fifo_level);
        end
        q.delete();
        model_fc = 0; exp_present = '0; exp_fcout = '0; exp_word = '0;
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (packet_ready !== 1'b0 || fifo_level !== 0) begin
            errors++; $display("FAIL post_reset_idle: ready=%b level=%0d required 0/0", packet_ready, fifo_level);
        end
        push_pair(24'h0000e1, 24'h0000f1);
        checks++;
        if (packet_ready !== 1'b0 || fifo_level !== 1) begin
            errors++; $display("FAIL ready_lat1: ready=%b level=%0d required 0/1", packet_ready, fifo_level);
        end
        @(negedge clk);
        checks++;
        if (packet_ready !== 1'b1) begin
            errors++; $display("FAIL ready_lat2: ready=%b required 1", packet_ready);
        end
        do_grant(0, '0, '0, 0);
        checks++;
        if (frame_counter !== 8'd0 || audio_sample_word[0] !== exp_word[0]) begin
            errors++; $display("FAIL post_reset_pkt: fc=%0d lane0=%h required 0/%h", frame_counter, audio_sample_word[0], exp_word[0]);
        end
        do_done();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_full_grant();
        test_ignored();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
